sram_arbiter: RTL and testbench

Two-port arbiter that shares one single-ported SRAM between the core's instruction-fetch port and data-memory port, so both can be served from one memory instance. It sits between the core and the SRAM wrapper, owns the SRAM address, write-enable and write-data lines, and routes read data back to the requester that issued the read. Data accesses take priority; an optional starvation guard bounds how long instruction fetch can be locked out.

---
 rtl/arb_pkg.sv | 19 +
 rtl/starve_counter.sv | 32 +++
 rtl/sram_arbiter.sv | 88 ++++++++
 tb/tb_sram_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the SRAM arbiter: response-owner encoding,
// default bus widths and the starvation-counter width helper.
package arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } rsp_own_t;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  // Bits needed to hold the values 0..max_wait inclusive.
  function automatic int cnt_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive refused IF cycles; at_max flags that the
// saturation value has been reached.
module starve_counter
  import arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = cnt_w(MAX_WAIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_max
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX_CNT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX_CNT);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-ported SRAM between instruction fetch and data memory.
// DM has priority; define ARB_STARVE_GUARD_EN to force-grant IF after MAX_WAIT refusals.
module sram_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [3:0]        dm_w_en,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_w_en,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  rsp_own_t rsp_own, rsp_own_nxt;
  logic     if_force;

`ifdef ARB_STARVE_GUARD_EN
  logic at_max;

  starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (if_gnt || !if_req),
    .en     (if_req && !if_gnt),
    .at_max (at_max)
  );

  assign if_force = if_req && at_max;
`else
  assign if_force = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_own <= OWN_NONE;
    end else begin
      rsp_own <= rsp_own_nxt;
    end
  end

  // Grants are held low during reset so nothing reaches the SRAM.
  always_comb begin
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    rsp_own_nxt = OWN_NONE;
    sram_addr   = if_addr;
    sram_w_en   = 4'b0000;
    if (!rst) begin
      if (dm_req && !if_force) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
    if (dm_gnt) begin
      sram_addr = dm_addr;
      sram_w_en = dm_w_en;
      if (dm_w_en == 4'b0000) begin
        rsp_own_nxt = OWN_DM;
      end
    end else if (if_gnt) begin
      rsp_own_nxt = OWN_IF;
    end
  end

  assign sram_wdata = dm_wdata;
  assign if_rvalid  = (rsp_own == OWN_IF);
  assign dm_rvalid  = (rsp_own == OWN_DM);
  assign if_rdata   = if_rvalid ? sram_rdata : '0;
  assign dm_rdata   = dm_rvalid ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, memory contents and response routing.
module tb_sram_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [3:0]        dm_w_en = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic              dm_gnt, dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [3:0]        sram_w_en;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_w_en(dm_w_en), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .sram_addr(sram_addr), .sram_w_en(sram_w_en), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- clock/reset helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req  = 1'b0;
    dm_req  = 1'b0;
    dm_w_en = 4'b0000;
  endtask

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4) return 32'h00500093;
    return 32'(idx + 1) * 32'h9E3779B1;
  endfunction

  // ---------------- SRAM model + reference model ----------------
  logic [31:0] sram_mem [0:16383];
  logic [31:0] ref_mem  [0:16383];
  bit          mem_init_done = 1'b0;
  int          starve_cnt = 0;
  int          exp_own = 0;      // 0 none, 1 IF, 2 DM
  logic [31:0] exp_data = '0;

  // {dm wins, if wins} for the current inputs under the arbitration rules.
  function automatic logic [1:0] model_grant();
    bit force_if, dm_win, if_win;
    if (rst) return 2'b00;
    force_if = GUARD && if_req && (starve_cnt >= MAX_WAIT);
    dm_win   = dm_req && !force_if;
    if_win   = if_req && !dm_win;
    return {dm_win, if_win};
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [1:0] g;
    if (!mem_init_done) begin
      for (int i = 0; i < 16384; i++) begin
        sram_mem[i] = init_word(i);
        ref_mem[i]  = init_word(i);
      end
      mem_init_done = 1'b1;
    end
    // SRAM: read-before-write, data appears the cycle after the address.
    sram_rdata <= sram_mem[sram_addr[15:2]];
    for (int b = 0; b < 4; b++)
      if (sram_w_en[b]) sram_mem[sram_addr[15:2]][8*b +: 8] = sram_wdata[8*b +: 8];
    if (rst) begin
      starve_cnt = 0;
      exp_own    = 0;
    end else begin
      g = model_grant();
      exp_own = 0;
      if (g[1]) begin
        if (dm_w_en == 4'b0000) begin
          exp_own  = 2;
          exp_data = ref_mem[dm_addr[15:2]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (dm_w_en[b]) ref_mem[dm_addr[15:2]][8*b +: 8] = dm_wdata[8*b +: 8];
        end
      end else if (g[0]) begin
        exp_own  = 1;
        exp_data = ref_mem[if_addr[15:2]];
      end
      if (if_req && !g[0]) starve_cnt = (starve_cnt < MAX_WAIT) ? starve_cnt + 1 : starve_cnt;
      else starve_cnt = 0;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    if_req = 1'b1; if_addr = 16'h1234; dm_req = 1'b1; dm_addr = 16'h0200; dm_w_en = 4'hF;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({if_gnt, dm_gnt} !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", {if_gnt, dm_gnt});
    else pass_cnt++;
    total_cnt++;
    if ({if_rvalid, dm_rvalid, sram_w_en} !== 6'b0) $display("FAIL reset_valid_wen got=%b exp=0", {if_rvalid, dm_rvalid, sram_w_en});
    else pass_cnt++;
    total_cnt++;
    if (sram_addr !== 16'h1234) $display("FAIL reset_addr got=%h exp=1234", sram_addr);
    else pass_cnt++;
    total_cnt++;
    if ({if_rdata, dm_rdata} !== 64'h0) $display("FAIL reset_rdata got=%h exp=0", {if_rdata, dm_rdata});
    else pass_cnt++;
    tick();
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_if_only();
    if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk);
    total_cnt++;
    if ({if_gnt, dm_gnt, sram_addr} !== {2'b10, 16'h0010}) $display("FAIL if_only_gnt got=%b/%h exp=10/0010", {if_gnt, dm_gnt}, sram_addr);
    else pass_cnt++;
    tick();
    if_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h00500093}) $display("FAIL if_only_data got=%b/%h exp=1/00500093", if_rvalid, if_rdata);
    else pass_cnt++;
    total_cnt++;
    if ({dm_rvalid, dm_rdata} !== 33'h0) $display("FAIL if_only_dm_idle got=%b/%h exp=0/0", dm_rvalid, dm_rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_collision();
    if_req = 1'b1; if_addr = 16'h0020; dm_req = 1'b1; dm_addr = 16'h0100; dm_w_en = 4'b0000;
    @(negedge clk);
    total_cnt++;
    if ({if_gnt, dm_gnt, sram_addr} !== {2'b01, 16'h0100}) $display("FAIL collision_gnt got=%b/%h exp=01/0100", {if_gnt, dm_gnt}, sram_addr);
    else pass_cnt++;
    tick();
    dm_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({dm_rvalid, dm_rdata, if_gnt} !== {1'b1, init_word(16'h0100 >> 2), 1'b1})
      $display("FAIL collision_dm_rsp got=%b/%h/%b exp=1/%h/1", dm_rvalid, dm_rdata, if_gnt, init_word(16'h0100 >> 2));
    else pass_cnt++;
    tick();
    if_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({if_rvalid, if_rdata} !== {1'b1, init_word(16'h0020 >> 2)}) $display("FAIL collision_if_rsp got=%b/%h exp=1/%h", if_rvalid, if_rdata, init_word(8));
    else pass_cnt++;
    tick();
  endtask

  task automatic test_dm_write();
    logic [31:0] w;
    w = init_word(16'h0040 >> 2);
    dm_req = 1'b1; dm_addr = 16'h0040; dm_w_en = 4'b0011; dm_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total_cnt++;
    if ({dm_gnt, sram_w_en, sram_wdata} !== {1'b1, 4'b0011, 32'hDEADBEEF}) $display("FAIL dm_write_issue got=%b/%b/%h exp=1/0011/deadbeef", dm_gnt, sram_w_en, sram_wdata);
    else pass_cnt++;
    tick();
    idle();
    @(negedge clk);
    total_cnt++;
    if ({dm_rvalid, sram_w_en} !== 5'b0) $display("FAIL dm_write_no_rsp got=%b/%b exp=0/0000", dm_rvalid, sram_w_en);
    else pass_cnt++;
    tick();
    dm_req = 1'b1; dm_w_en = 4'b0000;
    tick();
    dm_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({dm_rvalid, dm_rdata} !== {1'b1, w[31:16], 16'hBEEF}) $display("FAIL dm_write_merge got=%b/%h exp=1/%h", dm_rvalid, dm_rdata, {w[31:16], 16'hBEEF});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_starvation();
    int first_if = 0;
    int if_gnts = 0;
    logic dm_at_first = 1'b1;
    logic dm_c5 = 1'bx;
    idle();
    tick();
    if_req = 1'b1; if_addr = 16'h0030; dm_req = 1'b1; dm_addr = 16'h0050; dm_w_en = 4'b0000;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 5) dm_c5 = dm_gnt;
      if (if_gnt) begin
        if_gnts++;
        if (first_if == 0) begin
          first_if = c;
          dm_at_first = dm_gnt;
        end
      end
      tick();
    end
    total_cnt++;
    if (first_if !== (GUARD ? 5 : 0)) $display("FAIL starve_first_if got=%0d exp=%0d", first_if, GUARD ? 5 : 0);
    else pass_cnt++;
    total_cnt++;
    if (dm_c5 !== !GUARD) $display("FAIL starve_dm_cycle5 got=%b exp=%b", dm_c5, !GUARD);
    else pass_cnt++;
    total_cnt++;
    if (if_gnts !== (GUARD ? 2 : 0)) $display("FAIL starve_if_count got=%0d exp=%0d", if_gnts, GUARD ? 2 : 0);
    else pass_cnt++;
    total_cnt++;
    if (dm_at_first !== 1'b0 && first_if != 0) $display("FAIL starve_exclusive got=%b exp=0", dm_at_first);
    else pass_cnt++;
    dm_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({if_gnt, dm_gnt} !== 2'b10) $display("FAIL starve_release got=%b exp=10", {if_gnt, dm_gnt});
    else pass_cnt++;
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid_read();
    dm_req = 1'b1; dm_addr = 16'h0080; dm_w_en = 4'b0000; if_req = 1'b1; if_addr = 16'h0090;
    @(negedge clk);
    total_cnt++;
    if (dm_gnt !== 1'b1) $display("FAIL midrst_gnt got=%b exp=1", dm_gnt);
    else pass_cnt++;
    #2 rst = 1'b1;
    tick();
    total_cnt++;
    if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 4'b0) $display("FAIL midrst_during got=%b exp=0000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid});
    else pass_cnt++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({dm_gnt, if_gnt, dm_rvalid} !== 3'b100) $display("FAIL midrst_after got=%b exp=100", {dm_gnt, if_gnt, dm_rvalid});
    else pass_cnt++;
    tick();
    idle();
    @(negedge clk);
    total_cnt++;
    if ({dm_rvalid, dm_rdata} !== {1'b1, init_word(16'h0080 >> 2)}) $display("FAIL midrst_read got=%b/%h exp=1/%h", dm_rvalid, dm_rdata, init_word(32));
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      if_req  = (c < 3);
      if_addr = 16'(c * 4);
      @(negedge clk);
      total_cnt++;
      if (if_gnt !== (c < 3)) $display("FAIL b2b_gnt%0d got=%b exp=%b", c, if_gnt, c < 3);
      else pass_cnt++;
      if (c > 0) begin
        total_cnt++;
        if ({if_rvalid, if_rdata} !== {1'b1, init_word(c - 1)}) $display("FAIL b2b_data%0d got=%b/%h exp=1/%h", c, if_rvalid, if_rdata, init_word(c - 1));
        else pass_cnt++;
      end
      tick();
    end
    idle();
  endtask

  task automatic test_random();
    logic [1:0]  g;
    logic [15:0] e_addr;
    logic [3:0]  e_wen;
    int          errs = 0;
    for (int n = 0; n < 400; n++) begin
      if_req   = ($urandom_range(0, 3) != 0);
      if_addr  = 16'({$urandom_range(0, 63), 2'b00});
      dm_req   = ($urandom_range(0, 2) != 0);
      dm_addr  = 16'({$urandom_range(0, 63), 2'b00});
      dm_w_en  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      dm_wdata = $urandom;
      @(negedge clk);
      g      = model_grant();
      e_addr = g[1] ? dm_addr : if_addr;
      e_wen  = g[1] ? dm_w_en : 4'b0000;
      total_cnt++;
      if ({dm_gnt, if_gnt} !== g) begin
        $display("FAIL rnd_gnt n=%0d got=%b exp=%b", n, {dm_gnt, if_gnt}, g); errs++;
      end else pass_cnt++;
      total_cnt++;
      if ({sram_addr, sram_w_en, sram_wdata} !== {e_addr, e_wen, dm_wdata}) begin
        $display("FAIL rnd_sram n=%0d got=%h/%b exp=%h/%b", n, sram_addr, sram_w_en, e_addr, e_wen); errs++;
      end else pass_cnt++;
      total_cnt++;
      if ({if_rvalid, dm_rvalid} !== {exp_own == 1, exp_own == 2}) begin
        $display("FAIL rnd_rvalid n=%0d got=%b exp_owner=%0d", n, {if_rvalid, dm_rvalid}, exp_own); errs++;
      end else pass_cnt++;
      total_cnt++;
      if ({if_rdata, dm_rdata} !== {(exp_own == 1) ? exp_data : 32'h0, (exp_own == 2) ? exp_data : 32'h0}) begin
        $display("FAIL rnd_rdata n=%0d got=%h/%h exp=%h owner=%0d", n, if_rdata, dm_rdata, exp_data, exp_own); errs++;
      end else pass_cnt++;
      if (errs > 20) break;
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_collision();
    test_dm_write();
    test_starvation();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
